// File: rtl/cat_infer_sequencer.sv
// Runs one CatRecognizer inference: streams image words 1..NUM_WORDS, accumulates pixel*weight, adds bias, decides.
// done edge is NUM_WORDS+3 cycles after the start sample; one word per cycle, no backpressure (start_work low aborts).
module cat_infer_sequencer #(
    parameter int Amba_Word       = 24,
    parameter int Amba_Addr_Depth = 12,
    parameter int NUM_WORDS       = 4096,
    parameter int ACC_W           = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_work_i,
    output logic [Amba_Addr_Depth:0]   mem_addr_o,
    output logic                       mem_rd_o,
    input  logic [Amba_Word-1:0]       pix_word_i,
    input  logic [Amba_Word-1:0]       wgt_word_i,
    input  logic [Amba_Word-1:0]       bias_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       clear_start_o,
    output logic                       cat_result_o
);

    localparam int AW = Amba_Addr_Depth + 1;
    localparam int PW = 19;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t                   state_q;
    logic [AW-1:0]            mem_addr_q;
    logic                     mem_rd_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     clear_start_q;
    logic                     cat_result_q;
    logic                     drain_q;
    logic                     rd_vld_q;
    logic                     p_vld_q;
    logic signed [PW-1:0]     prod_q;
    logic signed [ACC_W-1:0]  acc_q;

    logic signed [PW-1:0]     prod_d;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  final_sum;
    logic                     cat_d;

    // Unsigned pixel times signed weight, both widened before the multiply.
    function automatic logic signed [PW-1:0] lane_mac(input logic [7:0] p, input logic [7:0] w);
        logic signed [PW-1:0] ps;
        logic signed [PW-1:0] ws;
        ps = signed'(PW'(p));
        ws = PW'(signed'(w));
        return ps * ws;
    endfunction

    always_comb begin
        prod_d = lane_mac(pix_word_i[Amba_Word-1 -: 8],  wgt_word_i[Amba_Word-1 -: 8])
               + lane_mac(pix_word_i[Amba_Word-9 -: 8],  wgt_word_i[Amba_Word-9 -: 8])
               + lane_mac(pix_word_i[Amba_Word-17 -: 8], wgt_word_i[Amba_Word-17 -: 8]);
        bias_ext  = ACC_W'(signed'(bias_i));
        final_sum = acc_q + bias_ext;
        cat_d     = ~final_sum[ACC_W-1] && (final_sum != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            mem_addr_q    <= '0;
            mem_rd_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            clear_start_q <= 1'b0;
            cat_result_q  <= 1'b0;
            drain_q       <= 1'b0;
            rd_vld_q      <= 1'b0;
            p_vld_q       <= 1'b0;
            prod_q        <= '0;
            acc_q         <= '0;
        end else begin
            done_q        <= 1'b0;
            clear_start_q <= 1'b0;
            rd_vld_q      <= mem_rd_q;
            p_vld_q       <= rd_vld_q;
            prod_q        <= prod_d;
            if (p_vld_q) begin
                acc_q <= acc_q + ACC_W'(prod_q);
            end

            case (state_q)
                S_IDLE: begin
                    if (start_work_i) begin
                        acc_q      <= '0;
                        p_vld_q    <= 1'b0;
                        mem_addr_q <= AW'(1);
                        mem_rd_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!start_work_i) begin
                        // Flush the valid pipe so aborted reads never reach acc.
                        mem_rd_q <= 1'b0;
                        busy_q   <= 1'b0;
                        rd_vld_q <= 1'b0;
                        p_vld_q  <= 1'b0;
                        state_q  <= S_IDLE;
                    end else if (mem_addr_q == LAST_ADDR) begin
                        mem_rd_q <= 1'b0;
                        drain_q  <= 1'b0;
                        state_q  <= S_DRAIN;
                    end else begin
                        mem_addr_q <= mem_addr_q + AW'(1);
                    end
                end
                S_DRAIN: begin
                    if (!start_work_i) begin
                        busy_q   <= 1'b0;
                        rd_vld_q <= 1'b0;
                        p_vld_q  <= 1'b0;
                        state_q  <= S_IDLE;
                    end else if (drain_q) begin
                        state_q <= S_DECIDE;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                S_DECIDE: begin
                    cat_result_q  <= cat_d;
                    done_q        <= 1'b1;
                    clear_start_q <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= S_DONE;
                end
                S_DONE: begin
                    if (!start_work_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr_o    = mem_addr_q;
    assign mem_rd_o      = mem_rd_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign clear_start_o = clear_start_q;
    assign cat_result_o  = cat_result_q;

endmodule
